// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the PC and issues single-word reads over a req/ack interface, keeping at
// most one read outstanding. Returned words go into a QDEPTH-entry queue whose
// head is presented to decode with its PC and the decoder's opcode fields.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   imem_req/addr       read request pulse and word address
//   imem_ack/rdata      read completion pulse and instruction word
//   redirect_valid/pc   taken branch/jump: flush and refetch from redirect_pc
//   stall               decode not accepting the head this cycle
//   instr_valid, instr, pc_out, pc_plus4, Op, funct3, funct7   head entry to decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [6:0]  Op,
    output logic [2:0]  funct3,
    output logic        funct7
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

    // IDLE: nothing outstanding; WAIT: read outstanding, keep it;
    // DRAIN: read outstanding but made stale by a redirect, drop it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   q_pc    [QDEPTH];
    logic [PW-1:0] head, tail, head_next, tail_next;
    logic [CW-1:0] count, count_next;
    logic          enq, deq, issue;
    logic [31:0]   head_instr_next, head_pc_next;

    // Queue bookkeeping, issue decision and next state.
    always_comb begin
        state_next      = state;
        enq             = 1'b0;
        deq             = 1'b0;
        issue           = 1'b0;
        count_next      = count;
        head_next       = head;
        tail_next       = tail;
        head_instr_next = q_instr[head];
        head_pc_next    = q_pc[head];

        if (redirect_valid) begin
            // Flush wins over enq/deq; an outstanding read becomes stale.
            count_next = '0;
            head_next  = '0;
            tail_next  = '0;
            case (state)
                WAIT:    state_next = imem_ack ? IDLE : DRAIN;
                DRAIN:   state_next = imem_ack ? IDLE : DRAIN;
                default: state_next = IDLE;
            endcase
        end else begin
            enq        = (state == WAIT) && imem_ack;
            deq        = instr_valid && !stall;
            count_next = count + CW'(enq) - CW'(deq);
            head_next  = head + PW'(deq);
            tail_next  = tail + PW'(enq);
            // Only issue with a free slot left for the read's eventual ack.
            issue      = !reset && (count_next < DEPTH) && ((state == IDLE) || enq);
            case (state)
                IDLE:    if (issue) state_next = WAIT;
                WAIT:    if (imem_ack) state_next = issue ? WAIT : IDLE;
                DRAIN:   if (imem_ack) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        // Next head may be the word being written this cycle (queue was empty).
        if (enq && (tail == head_next)) begin
            head_instr_next = imem_rdata;
            head_pc_next    = req_pc;
        end else begin
            head_instr_next = q_instr[head_next];
            head_pc_next    = q_pc[head_next];
        end
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    // State, PC and queue storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            req_pc   <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else begin
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'h0000_0003;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (issue) begin
                req_pc <= fetch_pc;
            end
            if (enq) begin
                q_instr[tail] <= imem_rdata;
                q_pc[tail]    <= req_pc;
            end
        end
    end

    // Registered head view; holds last values while the queue is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            pc_out      <= '0;
            pc_plus4    <= '0;
        end else begin
            instr_valid <= (count_next != '0);
            if (count_next != '0) begin
                instr    <= head_instr_next;
                pc_out   <= head_pc_next;
                pc_plus4 <= head_pc_next + 32'd4;
            end
        end
    end

    assign Op     = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a variable-latency memory
// model driven from the single stimulus process.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [6:0]  Op;
    logic [2:0]  funct3;
    logic        funct7;

    int          checks   = 0;
    int          failures = 0;

    // Memory model state.
    int          lat = 1;
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;
    int          pcnt = 0;
    logic        mr;
    logic [31:0] ma;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .Op             (Op),
        .funct3         (funct3),
        .funct7         (funct7)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h0010_0113;
            default:       mem_word = 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Sample the request at negedge, advance to posedge+1, update memory model.
    task automatic next_cycle();
        @(negedge clk);
        mr = imem_req;
        ma = imem_addr;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (mr) begin
                pend  = 1'b1;
                paddr = ma;
                pcnt  = lat;
            end
            if (pend) begin
                if (pcnt <= 1) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(paddr);
                    pend       = 1'b0;
                end else begin
                    pcnt--;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!instr_valid && n < budget) begin
            next_cycle();
            #1;
            n++;
        end
        check(tag, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;

        // Reset values.
        next_cycle();
        next_cycle();
        #1;
        check("rst_req",   32'(imem_req),    32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr,            32'd0);
        check("rst_pc",    pc_out,           32'd0);
        check("rst_pc4",   pc_plus4,         32'd0);
        check("rst_op",    32'(Op),          32'd0);
        check("rst_f3",    32'(funct3),      32'd0);
        check("rst_f7",    32'(funct7),      32'd0);

        // Basic fill, 1-cycle memory.
        lat = 1;
        do_reset();
        #1;
        check("s1_req0",  32'(imem_req), 32'd1);
        check("s1_addr0", imem_addr,     32'h0);
        next_cycle(); #1;
        check("s1_v1",    32'(instr_valid), 32'd0);
        check("s1_addr1", imem_addr,        32'h4);
        next_cycle(); #1;
        check("s1_v2",    32'(instr_valid), 32'd1);
        check("s1_pc2",   pc_out,           32'h0);
        check("s1_i2",    instr,            32'h0050_0093);
        check("s1_pc4_2", pc_plus4,         32'h4);
        check("s1_op2",   32'(Op),          32'h13);
        check("s1_f3_2",  32'(funct3),      32'd0);
        check("s1_f7_2",  32'(funct7),      32'd0);
        check("s1_addr2", imem_addr,        32'h8);
        next_cycle(); #1;
        check("s1_pc3",   pc_out,           32'h4);
        check("s1_i3",    instr,            32'h0010_0113);
        check("s1_op3",   32'(Op),          32'h13);

        // Stall: queue fills to two entries, requests stop.
        stall = 1'b1;
        #1;
        check("s2_req_full", 32'(imem_req), 32'd0);
        for (int i = 0; i < 6; i++) begin
            next_cycle(); #1;
            check("s2_hold_req", 32'(imem_req),    32'd0);
            check("s2_hold_v",   32'(instr_valid), 32'd1);
            check("s2_hold_pc",  pc_out,           32'h4);
        end
        stall = 1'b0;
        #1;
        check("s2_rel_req",  32'(imem_req), 32'd1);
        check("s2_rel_addr", imem_addr,     32'hC);
        for (int k = 1; k <= 3; k++) begin
            next_cycle(); #1;
            check("s2_seq_v",  32'(instr_valid), 32'd1);
            check("s2_seq_pc", pc_out,           32'(4 + 4 * k));
            check("s2_seq_i",  instr,            mem_word(32'(4 + 4 * k)));
        end

        // Redirect while a 2-cycle read is outstanding: stale ack drained.
        lat = 2;
        do_reset();
        next_cycle();           // c1
        next_cycle();           // c2 ack for 0x0, request 0x4
        next_cycle();           // c3 head pc 0x0
        next_cycle();           // c4 ack for 0x4, request 0x8
        next_cycle(); #1;       // c5 head pc 0x4, read 0x8 in flight
        check("s3_pc_pre", pc_out, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        check("s3_req_redir", 32'(imem_req), 32'd0);
        next_cycle();           // c6 stale ack arrives
        redirect_valid = 1'b0;
        #1;
        check("s3_v_flush",  32'(instr_valid), 32'd0);
        check("s3_req_drn",  32'(imem_req),    32'd0);
        next_cycle(); #1;       // c7
        check("s3_req_new",  32'(imem_req), 32'd1);
        check("s3_addr_new", imem_addr,     32'h100);
        wait_valid("s3_wait", 10);
        check("s3_pc",  pc_out, 32'h100);
        check("s3_i",   instr,  32'hC0DE_0100);
        check("s3_pc4", pc_plus4, 32'h104);

        // Redirect in the same cycle as an ack with a valid head.
        lat = 1;
        do_reset();
        stall = 1'b1;
        next_cycle(); #1;       // c1 ack 0x0
        check("s4_addr1", imem_addr, 32'h4);
        next_cycle(); #1;       // c2 head 0x0, ack 0x4
        check("s4_v2",  32'(instr_valid), 32'd1);
        check("s4_pc2", pc_out,           32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        check("s4_req_redir", 32'(imem_req), 32'd0);
        next_cycle();           // c3
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        check("s4_v3",    32'(instr_valid), 32'd0);
        check("s4_req3",  32'(imem_req),    32'd1);
        check("s4_addr3", imem_addr,        32'h200);
        wait_valid("s4_wait", 8);
        check("s4_pc", pc_out, 32'h200);
        check("s4_i",  instr,  32'hC0DE_0200);

        // Redirect to the top word: PC wraps to zero.
        lat = 1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        check("s5_req0", 32'(imem_req), 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check("s5_addr1", imem_addr, 32'hFFFF_FFFC);
        next_cycle(); #1;
        check("s5_addr2", imem_addr, 32'h0);
        next_cycle(); #1;
        check("s5_pc3",  pc_out,   32'hFFFF_FFFC);
        check("s5_pc4_3", pc_plus4, 32'h0);
        check("s5_i3",   instr,    32'h3F21_FFFC);
        next_cycle(); #1;
        check("s5_pc4",  pc_out,   32'h0);
        check("s5_pc4_4", pc_plus4, 32'h4);
        check("s5_i4",   instr,    32'h0050_0093);

        // Reset mid-read, then a stray ack right after release.
        lat = 3;
        do_reset();
        next_cycle(); #1;       // read to 0x0 outstanding
        check("s6_req_wait", 32'(imem_req), 32'd0);
        reset = 1'b1;
        #1;
        check("s6_rst_v",   32'(instr_valid), 32'd0);
        check("s6_rst_req", 32'(imem_req),    32'd0);
        next_cycle();
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("s6_req",  32'(imem_req), 32'd1);
        check("s6_addr", imem_addr,     32'h0);
        next_cycle(); #1;
        check("s6_v_stray", 32'(instr_valid), 32'd0);
        wait_valid("s6_wait", 8);
        check("s6_pc", pc_out, 32'h0);
        check("s6_i",  instr,  32'h0050_0093);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Owns the PC and issues word reads to instruction memory over a req/ack interface.
- Buffers returned words in a small FIFO and presents them, with their PC, to decode.
- Slices the Op, funct3 and funct7 fields that the control decoder consumes.
- Handles stall from decode and redirect from branch/jump resolution, including discarding an in-flight stale read.

Parameters:
- RESET_PC, 32'h00000000, PC fetched first after reset.
- QDEPTH, 2, instruction queue entries (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  one-cycle pulse; memory captures imem_addr.
- imem_addr  out  32  word address of request; bits [1:0] always 0.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid; ≥1 cycle after req.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  new PC; bits [1:0] forced to 0 internally.
- stall  in  1  decode not accepting this cycle.
- instr_valid  out  1  head entry valid.
- instr  out  32  head instruction word.
- pc_out  out  32  PC of head.
- pc_plus4  out  32  pc_out + 4, mod 2^32.
- Op  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  1  instr[30].

Behaviour:
- Reset (async, active-high):
  - fetch_pc=RESET_PC, queue empty, state IDLE, discard flag 0.
  - imem_req=0, instr_valid=0; instr, pc_out, Op, funct3 and funct7 all 0; pc_plus4=0.
  - First imem_req in the first clk edge cycle after reset deasserts.
  - Reset mid-WAIT abandons the in-flight read; a late ack after reset is ignored (state IDLE, not expecting).
- States:
  - IDLE: no read outstanding.
  - WAIT: one read outstanding, result kept.
  - DRAIN: one read outstanding, result discarded.
- At most one outstanding read, always.
- Dequeue: instr_valid & !stall. Enqueue: imem_ack in WAIT.
- Issue condition:
  - (count + enq − deq) < QDEPTH, and
  - state is IDLE, or state is WAIT with imem_ack this cycle, and
  - redirect_valid=0.
- On issue: imem_req=1, imem_addr=fetch_pc, fetch_pc+=4 (wraps at 2^32).
- Next state:
  - Issue → WAIT.
  - WAIT with ack and no issue → IDLE.
  - DRAIN with ack → IDLE; the ack data is dropped, and no issue happens that cycle.
- Throughput: with 1-cycle memory latency and no stall, one instruction per cycle after a 2-cycle fill.
- Enqueued word is visible at instr_valid the cycle after its ack (registered queue).
- Redirect (highest priority):
  - Same cycle: queue flushed (deq/enq ignored), fetch_pc<=redirect_pc&~3, no issue.
  - If state was WAIT and imem_ack=0 → DRAIN.
  - If WAIT and ack this cycle → data dropped, IDLE.
  - If DRAIN → stays DRAIN.
  - instr_valid=0 the next cycle.
- Redirect while in DRAIN: latest redirect_pc wins; only one ack is discarded.
- Full queue: no issue; in-flight ack always has a reserved slot (issue check guarantees no overflow).
- Empty queue: instr_valid=0; outputs hold last head values (don't-care to decode).
- Simultaneous enq+deq at full: legal only when the slot was reserved; count unchanged.
- Unexpected imem_ack in IDLE: ignored.

Test Plan:
- Reset → imem_addr=0x0, 1-cycle ack, no stall, rdata=0x00500093 then 0x00100113 → instr_valid cycles 3 and 4; pc_out 0x0 then 0x4; Op=0x13, funct3=0, funct7=0.
- Stall held 6 cycles, QDEPTH=2 → exactly 2 entries held; imem_req stays low once full. Release → 1 instr/cycle in PC order with no gaps or duplicates.
- Redirect to 0x103 while read to 0x8 is outstanding (ack 2 cycles later) → state DRAIN, that ack dropped. Next imem_addr=0x100; first instr_valid has pc_out=0x100.
- Redirect in the same cycle as an ack with a valid head → queue empties, ack data lost, next imem_addr=redirect target, instr_valid=0 the next cycle.
- Redirect_pc=0xFFFFFFFC → fetches 0xFFFFFFFC then 0x00000000; pc_plus4=0x0 for the first.
- Assert reset during WAIT, then send a stray ack → ignored. After release, imem_addr=RESET_PC and the queue is empty.
